data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the core's data-memory port (`data_re`/`data_we`/`data_addr`/`din` in; `read_data`/`cache_data_valid`/`cache_stall` out). It sits between the pipeline and the backing data memory. Read hits return in one cycle without stalling. Read misses stall the core while the line is filled, and every write stalls until the backing memory acknowledges it.

---
 rtl/data_cache_if.sv | 30 +++
 rtl/data_cache.sv | 143 ++++++++++++++
 tb/tb_data_cache.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// Core-side data-memory port and backing-memory port of the data cache.
// The cache connects through the slave modport; the environment (core plus
// backing memory) connects through the master modport.
interface data_cache_if;
  logic        data_re;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] din;
  logic [31:0] read_data;
  logic        cache_data_valid;
  logic        cache_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  data_re, data_we, data_addr, din, mem_rdata, mem_ack,
    output read_data, cache_data_valid, cache_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output data_re, data_we, data_addr, din, mem_rdata, mem_ack,
    input  read_data, cache_data_valid, cache_stall,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Read hits answer in one cycle; read misses fill from backing memory
// and replay; every write goes to backing memory and stalls until acked.
module data_cache #(
  parameter int unsigned INDEX_W = 8
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);
  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 32 - INDEX_W - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM} state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        read_data_q;
  logic               rvalid_q;

  logic [INDEX_W-1:0] req_idx;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               stall;
  logic               rd_hit;
  logic               latch_en;
  logic               wdata_en;
  logic               wr_hit_en;
  logic               fill_en;
  logic               mem_req;
  logic               mem_we;
  logic               unused_addr_bits;

  assign req_idx          = bus.data_addr[INDEX_W+1:2];
  assign req_tag          = bus.data_addr[31:INDEX_W+2];
  assign miss_idx         = addr_q[INDEX_W+1:2];
  assign hit              = (bus.data_re || bus.data_we) && valid_q[req_idx] &&
                            (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^bus.data_addr[1:0];

  assign bus.read_data        = read_data_q;
  assign bus.cache_data_valid = rvalid_q;
  assign bus.cache_stall      = stall;
  assign bus.mem_req          = mem_req;
  assign bus.mem_we           = mem_we;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_wdata        = wdata_q;

  // Next-state and control decode; a simultaneous read+write is a write.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    rd_hit    = 1'b0;
    latch_en  = 1'b0;
    wdata_en  = 1'b0;
    wr_hit_en = 1'b0;
    fill_en   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.data_we) begin
          stall     = 1'b1;
          latch_en  = 1'b1;
          wdata_en  = 1'b1;
          wr_hit_en = hit;
          state_d   = WR_MEM;
        end else if (bus.data_re) begin
          if (hit) begin
            rd_hit = 1'b1;
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (bus.mem_ack) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = !bus.mem_ack;
        if (bus.mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request, read result and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rd_hit;
      if (rd_hit) begin
        read_data_q <= data_q[req_idx];
      end
      if (latch_en) begin
        addr_q <= {bus.data_addr[31:2], 2'b00};
      end
      if (wdata_en) begin
        wdata_q <= bus.din;
      end
      if (fill_en) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage; left unreset, and writes are blocked during reset so a
  // late ack or write cannot corrupt a line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_hit_en) begin
        data_q[req_idx] <= bus.din;
      end
      if (fill_en) begin
        data_q[miss_idx] <= bus.mem_rdata;
        tag_q[miss_idx]  <= addr_q[31:INDEX_W+2];
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expected read results and
// expected backing-memory requests; monitors pop and compare them.
module tb_data_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if bus();

  data_cache #(.INDEX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  rd_exp_t     rd_q[$];
  mem_exp_t    mem_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          ack_delay   = 0;
  logic        ack_model   = 1'b0;
  logic        ack_manual  = 1'b0;
  logic [31:0] rdata_model = '0;
  logic [31:0] mem [logic [31:0]];

  assign bus.mem_ack   = ack_model | ack_manual;
  assign bus.mem_rdata = ack_manual ? 32'hBAD0_BAD0 : rdata_model;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-result monitor: every valid pulse must match the oldest expectation.
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.cache_data_valid === 1'b1) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got read_data %h with no read outstanding (cycle %0d)",
                   bus.read_data, cyc);
        end else begin
          e = rd_q.pop_front();
          check("read_data", bus.read_data, e.data);
          check("read_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Backing-memory model plus request monitor.
  initial begin
    int       k;
    bit       busy;
    mem_exp_t m;
    busy = 1'b0;
    k    = 0;
    forever begin
      @(posedge clk);
      #1;
      ack_model = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (!busy) begin
          busy = 1'b1;
          k    = 0;
          if (mem_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_mem_req: got addr %h we %b with none expected",
                     bus.mem_addr, bus.mem_we);
          end else begin
            m = mem_q.pop_front();
            check("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
            check("mem_addr", bus.mem_addr, m.addr);
            if (m.we) check("mem_wdata", bus.mem_wdata, m.wdata);
          end
        end else begin
          k++;
        end
        if (k == ack_delay) begin
          ack_model = 1'b1;
          busy      = 1'b0;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else rdata_model = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // In an ack cycle, reads still stall and writes release the core.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1)
        check("ack_stall", {31'b0, bus.cache_stall}, {31'b0, ~bus.mem_we});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input bit miss, input int exp_stall);
    int n    = 0;
    bit done = 1'b0;
    bus.data_re   = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = a;
    if (miss) mem_q.push_back('{we: 1'b0, addr: {a[31:2], 2'b00}, wdata: 32'h0});
    while (!done) begin
      @(negedge clk);
      if (bus.cache_stall === 1'b0) begin
        done = 1'b1;
        rd_q.push_back('{data: exp_data, cyc: cyc + 1});
      end else begin
        n++;
        if (n > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL read_timeout: got stall after %0d cycles expected release", n);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    check("read_stall_cycles", n, exp_stall);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input bit both, input int exp_stall);
    int n    = 0;
    bit done = 1'b0;
    bus.data_re   = both;
    bus.data_we   = 1'b1;
    bus.data_addr = a;
    bus.din       = d;
    mem_q.push_back('{we: 1'b1, addr: {a[31:2], 2'b00}, wdata: d});
    while (!done) begin
      @(negedge clk);
      if (bus.cache_stall === 1'b0) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          vectors++;
          miscompares++;
          $display("FAIL write_timeout: got stall after %0d cycles expected release", n);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    check("write_stall_cycles", n, exp_stall);
  endtask

  task automatic idle(input int n);
    bus.data_re = 1'b0;
    bus.data_we = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h500] = 32'h5555_AAAA;
    mem[32'h700] = 32'h7777_7777;
    rst           = 1'b1;
    bus.data_re   = 1'b0;
    bus.data_we   = 1'b0;
    bus.data_addr = '0;
    bus.din       = '0;

    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_valid", {31'b0, bus.cache_data_valid}, 32'h0);
    check("rst_stall", {31'b0, bus.cache_stall}, 32'h0);
    check("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Cold read, ack 3 cycles after mem_req rises: stall T..A = 5 cycles.
    ack_delay = 3;
    do_read(32'h100, 32'hDEAD_BEEF, 1'b1, 5);
    // Back-to-back hits, one with ignored low address bits.
    do_read(32'h100, 32'hDEAD_BEEF, 1'b0, 0);
    do_read(32'h102, 32'hDEAD_BEEF, 1'b0, 0);
    idle(1);

    // Write hit, ack one cycle after mem_req: stall T..A-1 = 2 cycles.
    ack_delay = 1;
    do_write(32'h100, 32'hCAFE_0001, 1'b0, 2);
    do_read(32'h100, 32'hCAFE_0001, 1'b0, 0);
    idle(1);

    // Write miss with ack in the first mem_req cycle, then a read miss there.
    ack_delay = 0;
    do_write(32'h200, 32'h1234_5678, 1'b0, 1);
    do_read(32'h200, 32'h1234_5678, 1'b1, 2);
    idle(1);

    // Read and write together act as a write (hit updates the line).
    ack_delay = 2;
    do_write(32'h100, 32'h0BAD_F00D, 1'b1, 3);
    do_read(32'h100, 32'h0BAD_F00D, 1'b0, 0);
    idle(1);

    // Reset while in RD_MISS, then a late ack.
    ack_delay     = 100;
    bus.data_re   = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_addr = 32'h700;
    mem_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0});
    @(negedge clk);
    check("miss_stall", {31'b0, bus.cache_stall}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("miss_mem_req", {31'b0, bus.mem_req}, 32'h1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.data_re = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    ack_manual = 1'b1;
    @(negedge clk);
    check("post_reset_mem_req", {31'b0, bus.mem_req}, 32'h0);
    @(posedge clk);
    #1;
    ack_manual = 1'b0;
    @(negedge clk);
    check("late_ack_mem_req", {31'b0, bus.mem_req}, 32'h0);
    check("late_ack_stall", {31'b0, bus.cache_stall}, 32'h0);
    @(posedge clk);
    #1;

    // Valid bits cleared, then a same-index conflict: three misses.
    ack_delay = 1;
    do_read(32'h100, 32'h0BAD_F00D, 1'b1, 3);
    do_read(32'h500, 32'h5555_AAAA, 1'b1, 3);
    do_read(32'h100, 32'h0BAD_F00D, 1'b1, 3);
    idle(4);

    check("rd_queue_drained", rd_q.size(), 32'h0);
    check("mem_queue_drained", mem_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
